// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Holds the loader state encoding and the partial-last-word helper.
package fabric_cfg_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK,
        ST_LATCH,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Bits of the final byte that actually reach the chain (1..WORD_W).
    function automatic int last_word_bits(input int chain_len);
        int words;
        words = (chain_len + WORD_W - 1) / WORD_W;
        return chain_len - WORD_W * (words - 1);
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// 8-bit parallel-in serial-out register feeding the configuration chain LSB-first.
module cfg_piso
    import fabric_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              sdo
);

    logic [WORD_W-1:0] reg_q;
    logic [WORD_W-1:0] reg_d;

    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = din;
        end else if (shift) begin
            reg_d = {1'b0, reg_q[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign sdo = reg_q[0];

endmodule

// File: rtl/fabric_config_loader.sv
// Loads checksummed configuration frames into the fabric's serial SRAM chain
// and releases switch isolation only after a successful latch.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              cfg_sdo,
    output logic              cfg_shift,
    output logic              cfg_latch,
    output logic              cfg_isolate,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN);
    localparam int WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [3:0]        FULL_CNT  = 4'(WORD_W);
    localparam logic [3:0]        LAST_CNT  = 4'(LAST_BITS);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                piso_load;
    logic                piso_shift;
    logic                piso_sdo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
        end
    end

    // start wins over everything, including a byte offered in the same cycle.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        if (start) begin
            state_d    = ST_LOAD;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            acc_d      = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (din_valid) begin
                        acc_d     = acc_q ^ din;
                        bit_cnt_d = (word_cnt_q == LAST_WORD) ? LAST_CNT : FULL_CNT;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d    = ST_LOAD;
                            word_cnt_d = word_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (din_valid) begin
                        state_d = (din == acc_q) ? ST_LATCH : ST_ERROR;
                    end
                end
                ST_LATCH: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        din_ready   = 1'b0;
        cfg_shift   = 1'b0;
        cfg_latch   = 1'b0;
        cfg_isolate = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state_q)
            ST_LOAD:  begin din_ready = 1'b1; busy = 1'b1; end
            ST_SHIFT: begin cfg_shift = 1'b1; busy = 1'b1; end
            ST_CHECK: begin din_ready = 1'b1; busy = 1'b1; end
            ST_LATCH: begin cfg_latch = 1'b1; busy = 1'b1; end
            ST_DONE:  begin done = 1'b1; cfg_isolate = 1'b0; end
            ST_ERROR: error = 1'b1;
            default:  ;
        endcase
        cfg_sdo = cfg_shift & piso_sdo;
    end

    assign piso_load  = (state_q == ST_LOAD) && din_valid && !start;
    assign piso_shift = (state_q == ST_SHIFT);

    cfg_piso u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (din),
        .sdo   (piso_sdo)
    );

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench for fabric_config_loader with 16- and 12-bit chains
// sharing one programming port.
module tb_fabric_config_loader;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start16;
    logic       start12;
    logic       din_valid;
    logic [7:0] din;

    logic r16_ready, r16_sdo, r16_shift, r16_latch, r16_iso, r16_busy, r16_done, r16_error;
    logic r12_ready, r12_sdo, r12_shift, r12_latch, r12_iso, r12_busy, r12_done, r12_error;

    always #5 clk = ~clk;

    fabric_config_loader #(.CHAIN_LEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .din(din), .din_valid(din_valid),
        .din_ready(r16_ready), .cfg_sdo(r16_sdo), .cfg_shift(r16_shift),
        .cfg_latch(r16_latch), .cfg_isolate(r16_iso), .busy(r16_busy),
        .done(r16_done), .error(r16_error)
    );

    fabric_config_loader #(.CHAIN_LEN(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .din(din), .din_valid(din_valid),
        .din_ready(r12_ready), .cfg_sdo(r12_sdo), .cfg_shift(r12_shift),
        .cfg_latch(r12_latch), .cfg_isolate(r12_iso), .busy(r12_busy),
        .done(r12_done), .error(r12_error)
    );

    // sel picks which loader the scenario talks to: 0 = 16-bit chain, 1 = 12-bit chain
    bit  sel;
    wire o_ready = sel ? r12_ready : r16_ready;
    wire o_sdo   = sel ? r12_sdo   : r16_sdo;
    wire o_shift = sel ? r12_shift : r16_shift;
    wire o_latch = sel ? r12_latch : r16_latch;
    wire o_iso   = sel ? r12_iso   : r16_iso;
    wire o_busy  = sel ? r12_busy  : r16_busy;
    wire o_done  = sel ? r12_done  : r16_done;
    wire o_error = sel ? r12_error : r16_error;

    int checks = 0;
    int fails  = 0;

    bit got[$];
    bit exp_bits[$];
    int latch_cnt, hs_cnt, cycles_to_end, viol_sdo, viol_iso, viol_ready;

    // Reference: the chain sees each byte LSB-first, truncated for the last word.
    function automatic void build_exp(input byte_q_t data, input int clen);
        int words;
        int nb;
        logic [7:0] b;
        words = (clen + 7) / 8;
        exp_bits.delete();
        for (int w = 0; w < words; w++) begin
            b  = data[w];
            nb = (w == words - 1) ? clen - 8 * (words - 1) : 8;
            for (int i = 0; i < nb; i++) exp_bits.push_back(b[i]);
        end
    endfunction

    function automatic int stream_mismatches();
        int m;
        m = 0;
        if (got.size() != exp_bits.size()) return 1000 + got.size();
        foreach (got[i]) if (got[i] !== exp_bits[i]) m++;
        return m;
    endfunction

    function automatic logic [7:0] xor_of(input byte_q_t data);
        logic [7:0] x;
        x = 8'h00;
        foreach (data[i]) x = x ^ data[i];
        return x;
    endfunction

    function automatic int frame_cycles(input int clen);
        int words;
        int lastb;
        words = (clen + 7) / 8;
        lastb = clen - 8 * (words - 1);
        return 9 * words - (8 - lastb) + 3;
    endfunction

    // Drives one frame (data bytes then checksum) and records what the chain saw.
    task automatic run_frame(input byte_q_t data, input logic [7:0] chk, input int gapmax,
                             input bit hold, input bit do_start);
        byte_q_t seq;
        int      idx;
        int      gap;
        bit      v_prev;
        bit      r_prev;
        seq = data;
        seq.push_back(chk);
        got.delete();
        latch_cnt = 0; hs_cnt = 0; cycles_to_end = -1;
        viol_sdo = 0; viol_iso = 0; viol_ready = 0;
        idx = 0;
        gap = hold ? 0 : $urandom_range(0, gapmax);
        if (do_start) begin
            @(negedge clk);
            if (sel) start12 = 1'b1;
            else     start16 = 1'b1;
        end
        din_valid = hold;
        din       = seq[0];
        v_prev    = din_valid;
        r_prev    = do_start ? 1'b0 : o_ready;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start16 = 1'b0;
            start12 = 1'b0;
            if (v_prev && r_prev) begin
                idx++;
                hs_cnt++;
                gap = hold ? 0 : $urandom_range(0, gapmax);
            end
            if (o_shift) got.push_back(o_sdo);
            else if (o_sdo !== 1'b0) viol_sdo++;
            if (o_latch) latch_cnt++;
            if (o_iso !== !o_done) viol_iso++;
            if (o_ready && (o_shift || o_latch || o_done || o_error)) viol_ready++;
            if (cycles_to_end < 0 && (o_done || o_error)) cycles_to_end = cyc;
            if (cycles_to_end >= 0 && cyc >= cycles_to_end + 2) break;
            if (idx < seq.size()) begin
                if (gap > 0) begin
                    din_valid = 1'b0;
                    din       = 8'($urandom);
                    gap--;
                end else begin
                    din_valid = 1'b1;
                    din       = seq[idx];
                end
            end else begin
                din_valid = hold;
                din       = 8'($urandom);
            end
            v_prev = din_valid;
            r_prev = o_ready;
        end
        din_valid = 1'b0;
        checks++;
        if (cycles_to_end < 0) begin
            fails++;
            $display("[TB] FAIL frame_timeout: done/error never seen, %0d handshakes of %0d", hs_cnt, seq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start16 = 1'b0; start12 = 1'b0; din_valid = 1'b0; din = 8'h00; sel = 1'b0;
        #12;
        checks++;
        if ({r16_ready, r16_sdo, r16_shift, r16_latch, r16_iso, r16_busy, r16_done, r16_error} !== 8'b00001000) begin
            fails++;
            $display("[TB] FAIL reset16: got %b expected 00001000",
                     {r16_ready, r16_sdo, r16_shift, r16_latch, r16_iso, r16_busy, r16_done, r16_error});
        end
        checks++;
        if ({r12_ready, r12_sdo, r12_shift, r12_latch, r12_iso, r12_busy, r12_done, r12_error} !== 8'b00001000) begin
            fails++;
            $display("[TB] FAIL reset12: got %b expected 00001000",
                     {r12_ready, r12_sdo, r12_shift, r12_latch, r12_iso, r12_busy, r12_done, r12_error});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_ready, o_busy, o_iso, o_done} !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL idle_wait: got %b expected 0010", {o_ready, o_busy, o_iso, o_done});
        end
    endtask

    task automatic test_frame16_good();
        byte_q_t d;
        d = '{8'hA5, 8'h3C};
        sel = 1'b0;
        run_frame(d, 8'h99, 0, 1'b1, 1'b1);
        build_exp(d, 16);
        checks++;
        if (stream_mismatches() !== 0) begin
            fails++; $display("[TB] FAIL good16_stream: %0d bad bits, %0d shifted, expected %0d", stream_mismatches(), got.size(), exp_bits.size());
        end
        checks++;
        if (latch_cnt !== 1) begin fails++; $display("[TB] FAIL good16_latch: got %0d pulses expected 1", latch_cnt); end
        checks++;
        if ({o_done, o_error, o_iso} !== 3'b100) begin
            fails++; $display("[TB] FAIL good16_status: done/error/iso got %b expected 100", {o_done, o_error, o_iso});
        end
        checks++;
        if (cycles_to_end !== frame_cycles(16)) begin
            fails++; $display("[TB] FAIL good16_time: got %0d cycles expected %0d", cycles_to_end, frame_cycles(16));
        end
        checks++;
        if (hs_cnt !== 3) begin fails++; $display("[TB] FAIL good16_handshakes: got %0d expected 3", hs_cnt); end
        checks++;
        if (viol_sdo + viol_iso + viol_ready !== 0) begin
            fails++; $display("[TB] FAIL good16_invariants: sdo %0d iso %0d ready %0d expected 0", viol_sdo, viol_iso, viol_ready);
        end
    endtask

    task automatic test_frame16_bad();
        byte_q_t d;
        d = '{8'hA5, 8'h3C};
        sel = 1'b0;
        run_frame(d, 8'h98, 0, 1'b1, 1'b1);
        checks++;
        if (latch_cnt !== 0) begin fails++; $display("[TB] FAIL bad16_latch: got %0d pulses expected 0", latch_cnt); end
        checks++;
        if ({o_done, o_error, o_iso} !== 3'b011) begin
            fails++; $display("[TB] FAIL bad16_status: done/error/iso got %b expected 011", {o_done, o_error, o_iso});
        end
        checks++;
        if (viol_iso !== 0) begin fails++; $display("[TB] FAIL bad16_isolate: %0d cycles wrong expected 0", viol_iso); end
    endtask

    task automatic test_frame12();
        byte_q_t d;
        d = '{8'hFF, 8'h0F};
        sel = 1'b1;
        run_frame(d, 8'hF0, 0, 1'b1, 1'b1);
        build_exp(d, 12);
        checks++;
        if (stream_mismatches() !== 0) begin
            fails++; $display("[TB] FAIL chain12_stream: %0d bad bits, %0d shifted, expected %0d", stream_mismatches(), got.size(), exp_bits.size());
        end
        checks++;
        if (latch_cnt !== 1 || o_done !== 1'b1) begin
            fails++; $display("[TB] FAIL chain12_done: latch %0d done %b expected 1 1", latch_cnt, o_done);
        end
        checks++;
        if (cycles_to_end !== frame_cycles(12)) begin
            fails++; $display("[TB] FAIL chain12_time: got %0d cycles expected %0d", cycles_to_end, frame_cycles(12));
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        byte_q_t d;
        d = '{8'hA5, 8'h3C};
        sel = 1'b0;
        for (int rep = 0; rep < 3; rep++) begin
            run_frame(d, 8'h99, 5, 1'b0, 1'b1);
            build_exp(d, 16);
            checks++;
            if (stream_mismatches() !== 0) begin
                fails++; $display("[TB] FAIL gaps_stream: rep %0d %0d bad bits", rep, stream_mismatches());
            end
            checks++;
            if (hs_cnt !== 3 || latch_cnt !== 1 || viol_ready !== 0) begin
                fails++; $display("[TB] FAIL gaps_handshake: hs %0d latch %0d ready_viol %0d expected 3 1 0", hs_cnt, latch_cnt, viol_ready);
            end
        end
    endtask

    task automatic test_abort();
        byte_q_t    d;
        logic [7:0] b0, b1;
        int         shcnt;
        int         latched;
        bit         aborted;
        sel = 1'b0;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        shcnt = 0; latched = 0; aborted = 1'b0;
        @(negedge clk);
        start16 = 1'b1; din_valid = 1'b1; din = b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (o_shift) shcnt++;
            if (o_latch) latched++;
            din = (shcnt >= 8) ? b1 : b0;
            if (shcnt == 11) begin
                start16 = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        checks++;
        if (aborted !== 1'b1) begin fails++; $display("[TB] FAIL abort_reach: shifted %0d expected 11", shcnt); end
        @(negedge clk);
        start16 = 1'b0; din_valid = 1'b0;
        if (o_latch) latched++;
        checks++;
        if ({o_ready, o_busy, o_shift, o_done, o_error, o_iso} !== 6'b110001) begin
            fails++; $display("[TB] FAIL abort_load: got %b expected 110001", {o_ready, o_busy, o_shift, o_done, o_error, o_iso});
        end
        d = '{8'($urandom), 8'($urandom)};
        run_frame(d, xor_of(d), 2, 1'b0, 1'b0);
        build_exp(d, 16);
        latched += latch_cnt;
        checks++;
        if (stream_mismatches() !== 0) begin
            fails++; $display("[TB] FAIL abort_reload_stream: %0d bad bits, %0d shifted", stream_mismatches(), got.size());
        end
        checks++;
        if (latched !== 1 || o_done !== 1'b1) begin
            fails++; $display("[TB] FAIL abort_reload_done: latches %0d done %b expected 1 1", latched, o_done);
        end
    endtask

    task automatic test_reset_midshift();
        bit seen;
        sel = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        start16 = 1'b1; din_valid = 1'b1; din = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (o_shift && c >= 2) begin seen = 1'b1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_reach: shift got 0 expected 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_sdo, o_shift, o_latch, o_iso, o_busy, o_done, o_error} !== 8'b00001000) begin
            fails++; $display("[TB] FAIL rst_mid_async: got %b expected 00001000",
                              {o_ready, o_sdo, o_shift, o_latch, o_iso, o_busy, o_done, o_error});
        end
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({o_ready, o_shift, o_latch, o_iso, o_busy, o_done} !== 6'b000100) begin
            fails++; $display("[TB] FAIL rst_mid_idle: got %b expected 000100", {o_ready, o_shift, o_latch, o_iso, o_busy, o_done});
        end
    endtask

    task automatic test_random();
        byte_q_t    d;
        logic [7:0] chk;
        bit         good;
        int         clen;
        for (int n = 0; n < 8; n++) begin
            sel  = n[0];
            clen = sel ? 12 : 16;
            d    = '{8'($urandom), 8'($urandom)};
            good = ($urandom_range(0, 3) != 0);
            chk  = good ? xor_of(d) : xor_of(d) ^ (8'h01 << $urandom_range(0, 7));
            run_frame(d, chk, 3, 1'b0, 1'b1);
            build_exp(d, clen);
            checks++;
            if (stream_mismatches() !== 0) begin
                fails++; $display("[TB] FAIL rand_stream: frame %0d len %0d %0d bad bits", n, clen, stream_mismatches());
            end
            checks++;
            if (latch_cnt !== int'(good) || o_done !== good || o_error !== !good || o_iso !== !good) begin
                fails++; $display("[TB] FAIL rand_status: frame %0d latch %0d done %b error %b iso %b expected good=%b",
                                  n, latch_cnt, o_done, o_error, o_iso, good);
            end
            checks++;
            if (viol_sdo + viol_iso + viol_ready !== 0) begin
                fails++; $display("[TB] FAIL rand_invariants: frame %0d sdo %0d iso %0d ready %0d expected 0",
                                  n, viol_sdo, viol_iso, viol_ready);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame16_good();
        test_frame16_bad();
        test_frame12();
        test_backpressure();
        test_abort();
        test_reset_midshift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fabric_config_loader.md
# fabric_config_loader

Sequences the configuration of the routing fabric's SRAM-controlled transmission-gate switches. Accepts configuration bytes from the external programming port over a valid/ready handshake and shifts them LSB-first into the serial SRAM configuration chain. Verifies an XOR checksum, then pulses a global latch that transfers the chain into the SRAM cells driving each gate's control input. Holds the fabric isolated, with all switches off, until a load completes successfully.

## Interface
- CHAIN_LEN, 64, number of SRAM bits in the configuration chain; must be ≥1.
- WORDS (localparam), ceil(CHAIN_LEN/8), number of data bytes per frame.

- clk  input  1  fabric configuration clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins or restarts a frame.
- din  input  8  configuration or checksum byte.
- din_valid  input  1  din is valid.
- din_ready  output  1  loader accepts din this cycle.
- cfg_sdo  output  1  serial data to the chain head.
- cfg_shift  output  1  chain shift enable; the chain advances on each clk edge while high.
- cfg_latch  output  1  one-cycle pulse that copies the chain into the switch SRAM cells.
- cfg_isolate  output  1  forces every transmission gate off while high.
- busy  output  1  a frame is in progress.
- done  output  1  last frame loaded and latched.
- error  output  1  last frame failed its checksum.

## Operation
- States: IDLE, LOAD, SHIFT, CHECK, LATCH, DONE, ERROR.
- IDLE: din_ready=0. On start → LOAD; clear word count, bit count and checksum accumulator.
- LOAD: din_ready=1. On din_valid&din_ready:
  - capture din into the shift register;
  - XOR din into the accumulator;
  - set bit count to 8, or to CHAIN_LEN−8·(WORDS−1) for the last word;
  - → SHIFT.
- SHIFT: din_ready=0, cfg_shift=1, cfg_sdo = shift register bit 0. The register shifts right each cycle.
  - After the final bit: → CHECK if this was word WORDS−1, otherwise → LOAD.
  - Unshifted high bits of a partial last word are discarded, but they are still included in the checksum.
- CHECK: din_ready=1. Accepted byte == accumulator → LATCH; otherwise → ERROR.
- LATCH: cfg_latch=1 for exactly one cycle, then → DONE.
- DONE: done=1, cfg_isolate=0. Stays until start.
- ERROR: error=1, cfg_isolate=1. cfg_latch never fires. Stays until start.
- start in any state other than IDLE aborts the current frame and restarts it:
  - → LOAD, all counters and the accumulator cleared;
  - cfg_isolate=1; done and error cleared.
- start has priority over a simultaneous din handshake; that byte is dropped.
- busy=1 in LOAD, SHIFT, CHECK and LATCH.
- cfg_isolate=1 in every state except DONE.
- cfg_sdo=0 whenever cfg_shift=0.

## Timing
- Reset values:
  - state=IDLE;
  - din_ready=0, cfg_sdo=0, cfg_shift=0, cfg_latch=0;
  - cfg_isolate=1;
  - busy=0, done=0, error=0.
- All outputs are registered or decoded from registered state only; no combinational path from input to output.
- Word accepted at edge N → first cfg_shift cycle is N+1 → full byte is shifted by edge N+8 → din_ready is back at 1 in cycle N+9.
- Minimum 9 cycles per full byte. Gaps in din_valid stretch LOAD and CHECK without limit.
- Checksum accepted at edge N → cfg_latch high in cycle N+1 → done=1 and cfg_isolate=0 in cycle N+2.
- Minimum frame time from start: 9·WORDS − (8 − last-word bits) + 3 cycles.
- Reset mid-frame: immediate return to the reset values. The chain contents are don't-care, and cfg_latch is never emitted.

## Structure
- Package fabric_cfg_pkg holds:
  - the state enum;
  - WORD_W=8;
  - a function returning the last-word bit count for a given CHAIN_LEN.
- One sub-module: cfg_piso, an 8-bit parallel-load, right-shift register with load, shift and bit-0 output.
- The FSM, counters and checksum stay in the top level.

## Test plan
- CHAIN_LEN=16, start, din 0xA5, 0x3C, checksum 0x99 → cfg_sdo sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0 over 16 cfg_shift cycles; one cfg_latch pulse; done=1, cfg_isolate=0.
- Same frame with checksum 0x98 → error=1, no cfg_latch, cfg_isolate stays 1.
- CHAIN_LEN=12, din 0xFF, 0x0F, checksum 0xF0 → 8+4 = 12 cfg_shift cycles, all sdo=1; latch; done=1.
- Backpressure: din_valid held high throughout → din_ready only in LOAD/CHECK, with exactly one byte per handshake. Random 0–5-cycle valid gaps → identical sdo stream.
- start pulsed in the 3rd SHIFT cycle of word 1 → abort, re-enter LOAD, accumulator cleared. A full new frame then loads correctly; no latch from the aborted frame.
- rst_n asserted mid-SHIFT → all outputs take reset values asynchronously; after release, IDLE waits for start.
